water_tank_lvl_multi: RTL and testbench

Multi-tank pump controller: the parametrised successor to the single-tank motor/level indicator. It drives one pump motor per tank from that tank's low and high level probes. Each channel adds probe debouncing, a minimum motor-off hold time, a fill-timeout fault for dry-run or stuck-probe cases, and a sensor-conflict fault with per-channel clear. It sits between the raw level-probe inputs and the motor drivers; all channels are independent and identical.

---
 rtl/water_tank_lvl_multi.sv | 174 +++++++++++++++++
 tb/tb_water_tank_lvl_multi.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/water_tank_lvl_multi.sv
// Multi-tank pump controller: per-tank probe sync/debounce, fill FSM, min-off hold, timeout and conflict faults.
// Probe-to-motor latency DEB_CYCLES+2 cycles; no backpressure, every output is a registered level.

module water_tank_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic flt
);
  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 1'b0;
      flt  <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= raw;
      if (sync != flt) begin
        if (cnt == CNT_LAST) begin
          flt <= sync;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module water_tank_ch #(
  parameter int MIN_OFF      = 8,
  parameter int FILL_TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic flt_low,
  input  logic flt_high,
  input  logic clr,
  output logic motor,
  output logic fault
);
  localparam int TW = (FILL_TIMEOUT < 2) ? 1 : $clog2(FILL_TIMEOUT + 1);
  localparam int HW = (MIN_OFF < 2) ? 1 : $clog2(MIN_OFF + 1);
  localparam logic [TW-1:0] TO_VAL  = TW'(FILL_TIMEOUT);
  localparam logic [HW-1:0] OFF_VAL = HW'(MIN_OFF);
  localparam bit TIMEOUT_EN = (FILL_TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, FILL, HOLDOFF, FAULT} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] fill_tmr;
  logic [HW-1:0] hold_cnt;
  logic          conflict;

  always_comb begin
    state_nxt = state;
    conflict  = flt_low & flt_high;
    case (state)
      IDLE: begin
        if (conflict)
          state_nxt = FAULT;
        else if (flt_low && !flt_high)
          state_nxt = FILL;
      end
      FILL: begin
        if (conflict)
          state_nxt = FAULT;
        else if (TIMEOUT_EN && (fill_tmr == TO_VAL))
          state_nxt = FAULT;
        else if (flt_high)
          state_nxt = HOLDOFF;
      end
      HOLDOFF: begin
        if (conflict)
          state_nxt = FAULT;
        else if (hold_cnt == OFF_VAL)
          state_nxt = IDLE;
      end
      FAULT: begin
        if (clr && !conflict)
          state_nxt = HOLDOFF;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      motor    <= 1'b0;
      fault    <= 1'b0;
      fill_tmr <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      motor <= (state_nxt == FILL);
      fault <= (state_nxt == FAULT);
      if (state_nxt == FILL) begin
        if (state != FILL)
          fill_tmr <= '0;
        else if (fill_tmr != TO_VAL)
          fill_tmr <= fill_tmr + 1'b1;
      end
      if (state_nxt == HOLDOFF) begin
        if (state != HOLDOFF)
          hold_cnt <= '0;
        else if (hold_cnt != OFF_VAL)
          hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
endmodule

module water_tank_lvl_multi #(
  parameter int N_TANKS      = 4,
  parameter int DEB_CYCLES   = 4,
  parameter int MIN_OFF      = 8,
  parameter int FILL_TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_TANKS-1:0] low_level,
  input  logic [N_TANKS-1:0] high_level,
  input  logic [N_TANKS-1:0] fault_clr,
  output logic [N_TANKS-1:0] motor,
  output logic [N_TANKS-1:0] fault,
  output logic               any_fault
);
  for (genvar i = 0; i < N_TANKS; i++) begin : g_ch
    logic flt_low;
    logic flt_high;

    water_tank_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_low (
      .clk   (clk),
      .reset (reset),
      .raw   (low_level[i]),
      .flt   (flt_low)
    );

    water_tank_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_high (
      .clk   (clk),
      .reset (reset),
      .raw   (high_level[i]),
      .flt   (flt_high)
    );

    water_tank_ch #(.MIN_OFF(MIN_OFF), .FILL_TIMEOUT(FILL_TIMEOUT)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .flt_low  (flt_low),
      .flt_high (flt_high),
      .clr      (fault_clr[i]),
      .motor    (motor[i]),
      .fault    (fault[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)
      any_fault <= 1'b0;
    else
      any_fault <= |fault;
  end
endmodule

// File: tb/tb_water_tank_lvl_multi.sv
// Bench for water_tank_lvl_multi: directed test-plan steps, then randomized probes checked every cycle
// against a behavioural model (mismatch run lengths, remaining off-time, time-on-motor).
module tb_water_tank_lvl_multi;
  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int MOFF = 8;
  localparam int TO   = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] low_level, high_level, fault_clr;
  logic [N-1:0] motor, fault;
  logic         any_fault;

  water_tank_lvl_multi #(
    .N_TANKS(N), .DEB_CYCLES(DEB), .MIN_OFF(MOFF), .FILL_TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .low_level  (low_level),
    .high_level (high_level),
    .fault_clr  (fault_clr),
    .motor      (motor),
    .fault      (fault),
    .any_fault  (any_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         m_sync_l [N];
  bit         m_sync_h [N];
  bit         m_flt_l  [N];
  bit         m_flt_h  [N];
  int         m_run_l  [N];
  int         m_run_h  [N];
  int         m_age    [N];  // cycles the motor has been on, counted after each edge
  int         m_off    [N];  // holdoff cycles still to serve; 0 = not holding
  bit [N-1:0] m_motor;
  bit [N-1:0] m_fault;
  bit         m_any;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void deb(input bit s, input bit f_in, input int run_in,
                              output bit f, output int run);
    f   = f_in;
    run = (s != f_in) ? run_in + 1 : 0;
    if (run >= DEB) begin
      f   = s;
      run = 0;
    end
  endfunction

  task automatic model_step();
    bit conf;
    if (reset) begin
      for (int c = 0; c < N; c++) begin
        m_sync_l[c] = 0; m_sync_h[c] = 0; m_flt_l[c] = 0; m_flt_h[c] = 0;
        m_run_l[c] = 0;  m_run_h[c] = 0;  m_age[c] = 0;   m_off[c] = 0;
      end
      m_motor = '0;
      m_fault = '0;
      m_any   = 0;
    end else begin
      m_any = |m_fault;
      for (int c = 0; c < N; c++) begin
        conf = m_flt_l[c] & m_flt_h[c];
        if (m_fault[c]) begin
          if (fault_clr[c] && !conf) begin
            m_fault[c] = 0;
            m_off[c]   = MOFF + 1;
          end
        end else if (conf) begin
          m_motor[c] = 0;
          m_fault[c] = 1;
          m_off[c]   = 0;
        end else if (m_motor[c]) begin
          if (TO != 0 && m_age[c] >= TO + 1) begin
            m_motor[c] = 0;
            m_fault[c] = 1;
          end else if (m_flt_h[c]) begin
            m_motor[c] = 0;
            m_off[c]   = MOFF + 1;
          end else begin
            m_age[c]++;
          end
        end else if (m_off[c] > 0) begin
          m_off[c]--;
        end else if (m_flt_l[c] && !m_flt_h[c]) begin
          m_motor[c] = 1;
          m_age[c]   = 1;
        end
        deb(m_sync_l[c], m_flt_l[c], m_run_l[c], m_flt_l[c], m_run_l[c]);
        deb(m_sync_h[c], m_flt_h[c], m_run_h[c], m_flt_h[c], m_run_h[c]);
        m_sync_l[c] = low_level[c];
        m_sync_h[c] = high_level[c];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("motor", 32'(motor), 32'(m_motor));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("any_fault", 32'(any_fault), 32'(m_any));
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    reset      = 1'b1;
    low_level  = '0;
    high_level = '0;
    fault_clr  = '0;

    // Reset and basic fill on tank 0
    ticks(2);
    chk("rst_motor", 32'(motor), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_any", 32'(any_fault), 0);
    reset = 1'b0;
    low_level[0] = 1'b1;
    ticks(5);
    chk("fill_pre", 32'(motor[0]), 0);
    tick();
    chk("fill_lat6", 32'(motor[0]), 1);
    chk("others_off", 32'(motor[3:1]), 0);

    high_level[0] = 1'b1;
    low_level[0]  = 1'b0;
    ticks(5);
    chk("stop_pre", 32'(motor[0]), 1);
    tick();
    chk("stop_lat6", 32'(motor[0]), 0);

    // Min-off: low reasserted straight away
    low_level[0]  = 1'b1;
    high_level[0] = 1'b0;
    ticks(9);
    chk("minoff_hold", 32'(motor[0]), 0);
    tick();
    chk("minoff_refill", 32'(motor[0]), 1);

    // Timeout: high never comes
    ticks(20);
    chk("to_motor_on", 32'(motor[0]), 1);
    chk("to_fault_pre", 32'(fault[0]), 0);
    tick();
    chk("to_motor_off", 32'(motor[0]), 0);
    chk("to_fault", 32'(fault[0]), 1);
    chk("to_any_lag", 32'(any_fault), 0);
    tick();
    chk("to_any", 32'(any_fault), 1);
    low_level[0] = 1'b0;

    // Debounce on tank 1
    low_level[1] = 1'b1;
    ticks(3);
    low_level[1] = 1'b0;
    ticks(8);
    chk("glitch3", 32'(motor[1]), 0);
    low_level[1] = 1'b1;
    ticks(4);
    low_level[1] = 1'b0;
    ticks(2);
    chk("pulse4", 32'(motor[1]), 1);
    high_level[1] = 1'b1;
    ticks(8);
    high_level[1] = 1'b0;
    chk("pulse4_stop", 32'(motor[1]), 0);

    // Conflict and clear on tank 2 (tank 0 timeout fault cleared alongside)
    low_level[2]  = 1'b1;
    high_level[2] = 1'b1;
    ticks(6);
    chk("conf_fault", 32'(fault[2]), 1);
    chk("conf_motor", 32'(motor[2]), 0);
    fault_clr[2] = 1'b1;
    tick();
    fault_clr[2] = 1'b0;
    chk("clr_blocked", 32'(fault[2]), 1);
    low_level[2]  = 1'b0;
    high_level[2] = 1'b0;
    ticks(6);
    fault_clr    = 4'b0101;
    low_level[2] = 1'b1;
    tick();
    fault_clr = '0;
    chk("clr_ok", 32'(fault[2]), 0);
    chk("clr_ok0", 32'(fault[0]), 0);
    ticks(9);
    chk("clr_hold", 32'(motor[2]), 0);
    tick();
    chk("clr_refill", 32'(motor[2]), 1);
    high_level[2] = 1'b1;
    low_level[2]  = 1'b0;
    ticks(8);
    high_level[2] = 1'b0;

    // All tanks together, then reset mid-fill
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    low_level = '1;
    ticks(6);
    chk("all_fill", 32'(motor), 32'hF);
    ticks(3);
    reset = 1'b1;
    tick();
    chk("midrst_motor", 32'(motor), 0);
    chk("midrst_fault", 32'(fault), 0);
    chk("midrst_any", 32'(any_fault), 0);
    reset     = 1'b0;
    low_level = '0;
    ticks(2);

    // Randomized probes, clears and occasional reset
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 9) == 0)  low_level[c]  = ~low_level[c];
        if ($urandom_range(0, 11) == 0) high_level[c] = ~high_level[c];
      end
      fault_clr = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      reset     = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
